// File: rtl/pipo_write_arbiter_if.sv
// Write-request bus between client requesters and the PIPO write arbiter.
// Clients drive req/data_in; the arbiter returns grant and the stored-word status.
interface pipo_write_arbiter_if #(
    parameter int N = 4,
    parameter int R = 4
);
    localparam int OW = (R > 1) ? $clog2(R) : 1;

    logic [R-1:0]   req;
    logic [R*N-1:0] data_in;
    logic [R-1:0]   grant;
    logic [N-1:0]   parallel_out;
    logic [OW-1:0]  owner;
    logic           updated;
    logic           busy;

    modport master (
        output req, data_in,
        input  grant, parallel_out, owner, updated, busy
    );

    modport slave (
        input  req, data_in,
        output grant, parallel_out, owner, updated, busy
    );
endinterface

// File: rtl/pipo_write_arbiter.sv
// Round-robin, four-phase write arbiter in front of the shared N-bit PIPO register.
// One requester is granted at a time and its word is loaded on the edge leaving GRANT.
module pipo_write_arbiter #(
    parameter int N = 4,
    parameter int R = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    pipo_write_arbiter_if.slave   bus
);
    localparam int OW = (R > 1) ? $clog2(R) : 1;
    localparam logic [OW-1:0] LAST_IDX  = OW'(R - 1);
    localparam logic [R-1:0]  GRANT_LSB = {{(R-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } state_t;

    state_t         state_r;
    logic [OW-1:0]  ptr_r;
    logic [OW-1:0]  win_r;
    logic [R-1:0]   grant_r;
    logic [N-1:0]   pout_r;
    logic [OW-1:0]  owner_r;
    logic           updated_r;
    logic           busy_r;
    logic [OW-1:0]  pick_s;
    logic [N-1:0]   sel_s;

    // First set request at or above p, wrapping modulo R.
    function automatic logic [OW-1:0] pick_winner(input logic [R-1:0] r, input logic [OW-1:0] p);
        logic [OW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < R; k++) begin
            idx = (int'(p) + k) % R;
            if (!found && r[idx]) begin
                w     = OW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    // Round-robin winner from the live request vector.
    always_comb begin
        pick_s = pick_winner(bus.req, ptr_r);
    end

    // Write-data slice belonging to the latched winner.
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < R; i++) begin
            if (win_r == OW'(i)) begin
                sel_s = bus.data_in[i*N +: N];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Arbitration FSM with registered grant, stored word and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            win_r     <= '0;
            grant_r   <= '0;
            pout_r    <= '0;
            owner_r   <= '0;
            updated_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    updated_r <= 1'b0;
                    if (|bus.req) begin
                        win_r   <= pick_s;
                        grant_r <= GRANT_LSB << pick_s;
                        state_r <= GRANT;
                        busy_r  <= 1'b1;
                    end else begin
                        grant_r <= '0;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                GRANT: begin
                    // Commit regardless of req[win] so a fast-dropping winner still writes.
                    grant_r   <= '0;
                    pout_r    <= sel_s;
                    owner_r   <= win_r;
                    ptr_r     <= (win_r == LAST_IDX) ? '0 : win_r + OW'(1);
                    updated_r <= 1'b1;
                    state_r   <= RELEASE;
                    busy_r    <= 1'b1;
                end
                RELEASE: begin
                    grant_r   <= '0;
                    updated_r <= 1'b0;
                    if (bus.req[win_r]) begin
                        state_r <= RELEASE;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    grant_r   <= '0;
                    updated_r <= 1'b0;
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant        = grant_r;
    assign bus.parallel_out = pout_r;
    assign bus.owner        = owner_r;
    assign bus.updated      = updated_r;
    assign bus.busy         = busy_r;
endmodule
